// File: rtl/gbsha_fir_top.sv
// ---------------------------------------------------------------------------
// gbsha_fir_top
//   Fixed-coefficient 4-tap FIR filter tile on an 8-in/8-out pad ring.
//   A 2-bit unsigned sample is taken on every rising clock edge. The output
//   is the registered weighted sum of the current sample and the three
//   previous samples. The output saturates at 15 and never wraps.
//
// Parameters
//   H0..H3  2-bit unsigned weights for x[n], x[n-1], x[n-2] and x[n-3]
//
// Ports
//   io_in[0]     clk    rising-edge clock
//   io_in[1]     rst_n  asynchronous, active-low reset
//   io_in[3:2]   x_in   unsigned input sample, 0..3
//   io_in[7:4]   unused, ignored
//   io_out[3:0]  y_out  registered, saturated filter output, 0..15
//   io_out[7:4]  constant 4'b0000
//
// Handshake: there is none. A new sample is consumed on every clock edge,
// and y_out is valid one edge after the sample that produced it.
// ---------------------------------------------------------------------------
module gbsha_fir_top #(
  parameter logic [1:0] H0 = 2'd1,
  parameter logic [1:0] H1 = 2'd1,
  parameter logic [1:0] H2 = 2'd1,
  parameter logic [1:0] H3 = 2'd1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       clk;
  logic       rst_n;
  logic [1:0] x_in;
  logic       unused_pins;

  assign clk         = io_in[0];
  assign rst_n       = io_in[1];
  assign x_in        = io_in[3:2];
  assign unused_pins = ^io_in[7:4];

  logic [1:0] d0, d1, d2;
  logic [3:0] y;
  logic [5:0] s;
  logic [3:0] y_next;

  // Every product is at most 3*3 = 9, so the sum of four is at most 36.
  // Six bits hold that without overflow.
  always_comb begin
    s = (6'(H0) * 6'(x_in)) + (6'(H1) * 6'(d0))
      + (6'(H2) * 6'(d1)) + (6'(H3) * 6'(d2));
    y_next = (s > 6'd15) ? 4'd15 : s[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= 2'd0;
      d1 <= 2'd0;
      d2 <= 2'd0;
      y  <= 4'd0;
    end else begin
      d0 <= x_in;
      d1 <= d0;
      d2 <= d1;
      y  <= y_next;
    end
  end

  assign io_out = {4'b0000, y};

endmodule

// File: tb/tb_gbsha_fir_top.sv
// ---------------------------------------------------------------------------
// tb_gbsha_fir_top
//   Directed bench for gbsha_fir_top. Two instances share one input bus:
//   dut_def keeps the default weights (all 1), and dut_sat uses weights of 3
//   so that its output clamps at 15. Each step drives x_in, waits for the
//   rising edge, and checks both outputs 1 time unit later.
// ---------------------------------------------------------------------------
module tb_gbsha_fir_top;

  // ---------------- clock / reset / pads ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] x_in  = 2'd0;
  logic [3:0] junk  = 4'd0;
  logic [7:0] io_in;
  logic [7:0] io_out_def;
  logic [7:0] io_out_sat;

  always #5 clk = ~clk;

  assign io_in = {junk, x_in, rst_n, clk};

  gbsha_fir_top dut_def (
    .io_in  (io_in),
    .io_out (io_out_def)
  );

  gbsha_fir_top #(
    .H0(2'd3), .H1(2'd3), .H2(2'd3), .H3(2'd3)
  ) dut_sat (
    .io_in  (io_in),
    .io_out (io_out_sat)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_sat_q[$];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_def, input logic [3:0] e_sat);
    check({tag, " y_def"}, io_out_def[3:0], e_def);
    check({tag, " y_sat"}, io_out_sat[3:0], e_sat);
    check({tag, " hi_def"}, io_out_def[7:4], 4'd0);
    check({tag, " hi_sat"}, io_out_sat[7:4], 4'd0);
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 unit after the rising edge, well away from the next one.
  task automatic step(input string tag, input logic [1:0] x, input logic [3:0] e_def,
                      input logic [3:0] e_sat);
    x_in = x;
    junk = 4'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    check_all(tag, e_def, e_sat);
  endtask

  // Drains the expected queues, applying the same sample every edge.
  task automatic run_queue(input string tag, input logic [1:0] x);
    while (exp_q.size() > 0 && exp_sat_q.size() > 0) begin
      step(tag, x, exp_q.pop_front(), exp_sat_q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    x_in  = 2'd0;
    #1;
    check_all("reset_async", 4'd0, 4'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // 1. Reset held: clock edges with x_in=3 must leave everything at 0.
    rst_n = 1'b0;
    x_in  = 2'd3;
    #1;
    check_all("reset_initial", 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      junk = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check_all("reset_held", 4'd0, 4'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // 2. Impulse: one sample of 3, then zeros.
    step("impulse", 2'd3, 4'd3, 4'd9);
    step("impulse", 2'd0, 4'd3, 4'd9);
    step("impulse", 2'd0, 4'd3, 4'd9);
    step("impulse", 2'd0, 4'd3, 4'd9);
    step("impulse", 2'd0, 4'd0, 4'd0);
    step("impulse", 2'd0, 4'd0, 4'd0);

    // 3. Step up, then step down. Saturating instance: s = 9,18,27,36.
    do_reset();
    exp_q     = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd12, 4'd12};
    exp_sat_q = '{4'd9, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    run_queue("step_up", 2'd3);
    exp_q     = '{4'd9, 4'd6, 4'd3, 4'd0};
    exp_sat_q = '{4'd15, 4'd15, 4'd9, 4'd0};
    run_queue("step_down", 2'd0);

    // 4. Mixed sequence 1,2,0,3,1.
    do_reset();
    step("mixed", 2'd1, 4'd1, 4'd3);
    step("mixed", 2'd2, 4'd3, 4'd9);
    step("mixed", 2'd0, 4'd3, 4'd9);
    step("mixed", 2'd3, 4'd6, 4'd15);
    step("mixed", 2'd1, 4'd6, 4'd15);

    // 5. Mid-run reset after reaching 12, then restart with empty history.
    do_reset();
    exp_q     = '{4'd3, 4'd6, 4'd9, 4'd12};
    exp_sat_q = '{4'd9, 4'd15, 4'd15, 4'd15};
    run_queue("midrun_fill", 2'd3);
    rst_n = 1'b0;
    #1;
    check_all("midrun_async", 4'd0, 4'd0);
    #1;
    rst_n = 1'b1;
    exp_q     = '{4'd1, 4'd2, 4'd3, 4'd4};
    exp_sat_q = '{4'd3, 4'd6, 4'd9, 4'd12};
    run_queue("midrun_restart", 2'd1);

    // 6. Saturation on its own, weights 3: 9,15,15,15.
    do_reset();
    exp_q     = '{4'd3, 4'd6, 4'd9, 4'd12};
    exp_sat_q = '{4'd9, 4'd15, 4'd15, 4'd15};
    run_queue("saturate", 2'd3);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
